// File: rtl/product_accumulator.sv
// product_accumulator: sums each group of ACC_LEN consecutive valid products from the
// array multiplier into one result and presents results through a 2-entry FIFO with a
// valid/ready handshake. The input has no backpressure, so a result that finds the FIFO
// full (and no pop in the same cycle) is dropped and the sticky o_overflow flag is set.
//
// Optional build macro: PRODUCT_ACCUMULATOR_FLUSH_EN adds i_flush, which closes an open
// group early and pushes its partial sum as a short-group result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   i_valid    product valid (multiplier o_valid)
//   i_product  unsigned product (multiplier Z_final)
//   i_flush    (macro only) push the open group's partial sum now
//   o_valid    FIFO not empty
//   o_ready    downstream accepts the head result this cycle
//   o_sum      FIFO head result
//   o_overflow sticky: a completed result was dropped; cleared only by reset
module product_accumulator #(
  parameter int unsigned DATAWIDTH  = 4,
  parameter int unsigned PROD_WIDTH = 2 * DATAWIDTH,
  parameter int unsigned ACC_LEN    = 4,
  parameter int unsigned ACC_WIDTH  = PROD_WIDTH + $clog2(ACC_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [PROD_WIDTH-1:0] i_product,
`ifdef PRODUCT_ACCUMULATOR_FLUSH_EN
  input  logic                  i_flush,
`endif
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [ACC_WIDTH-1:0]  o_sum,
  output logic                  o_overflow
);

  localparam int unsigned CntW = $clog2(ACC_LEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(ACC_LEN - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               state_q;
  logic [CntW-1:0]      count_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] buf0_q;  // FIFO head
  logic [ACC_WIDTH-1:0] buf1_q;
  logic [1:0]           fill_q;
  logic                 ovf_q;

  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum_next;
  logic                 group_done;
  logic                 flush_req;
  logic                 push;
  logic                 pop;

  always_comb begin
    prod_ext   = ACC_WIDTH'(i_product);
    // acc_q is zero while idle, so this is also the correct value for a one-product flush.
    sum_next   = acc_q + (i_valid ? prod_ext : '0);
    group_done = i_valid && (state_q == StRun) && (count_q == LastCnt);
`ifdef PRODUCT_ACCUMULATOR_FLUSH_EN
    flush_req  = i_flush && ((state_q == StRun) || i_valid);
`else
    flush_req  = 1'b0;
`endif
    // A flush on the cycle that completes a group still yields a single push.
    push       = group_done || flush_req;
    pop        = (fill_q != 2'd0) && o_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      acc_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      fill_q  <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      // Group accumulator FSM; count returns to 0 even when the result is dropped,
      // so group alignment never slips.
      if (push) begin
        state_q <= StIdle;
        count_q <= '0;
        acc_q   <= '0;
      end else if (i_valid) begin
        unique case (state_q)
          StIdle: begin
            acc_q   <= prod_ext;
            count_q <= CntW'(1);
            state_q <= StRun;
          end
          StRun: begin
            acc_q   <= sum_next;
            count_q <= count_q + CntW'(1);
          end
          default: state_q <= StIdle;
        endcase
      end

      // Result FIFO: buf0 is always the head, buf1 the tail when two are held.
      unique case ({push, pop})
        2'b10: begin
          if (fill_q == 2'd0) begin
            buf0_q <= sum_next;
            fill_q <= 2'd1;
          end else if (fill_q == 2'd1) begin
            buf1_q <= sum_next;
            fill_q <= 2'd2;
          end else begin
            ovf_q  <= 1'b1;
          end
        end
        2'b01: begin
          buf0_q <= buf1_q;
          buf1_q <= '0;
          fill_q <= fill_q - 2'd1;
        end
        2'b11: begin
          // Pop frees a slot first, so a push into a full FIFO still succeeds.
          if (fill_q == 2'd1) begin
            buf0_q <= sum_next;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= sum_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid    = (fill_q != 2'd0);
  assign o_sum      = buf0_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (DATAWIDTH=4, ACC_LEN=4, ACC_WIDTH=10).
// A reference model tracks the open group; completed results go into an expected queue
// (capacity 2) and are compared against o_sum when the DUT presents them.
module tb_product_accumulator;

  localparam int unsigned AccLen = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic [7:0] i_product;
  logic       o_valid;
  logic       o_ready;
  logic [9:0] o_sum;
  logic       o_overflow;
  logic       flush;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [9:0]  exp_q[$];
  logic [9:0]  m_acc;
  int unsigned m_cnt;
  logic        m_ovf;

  always #5 clk = ~clk;

  product_accumulator #(
    .DATAWIDTH (4),
    .PROD_WIDTH(8),
    .ACC_LEN   (4),
    .ACC_WIDTH (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_product (i_product),
`ifdef PRODUCT_ACCUMULATOR_FLUSH_EN
    .i_flush   (flush),
`endif
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_sum     (o_sum),
    .o_overflow(o_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of stimulus, compare outputs mid-cycle, then advance the model.
  task automatic step(input logic v, input logic [7:0] p, input logic r);
    logic       push;
    logic       pop;
    logic       f;
    logic [9:0] pd;
    i_valid   = v;
    i_product = p;
    o_ready   = r;
    @(negedge clk);
    check("o_valid", o_valid, (exp_q.size() != 0));
    if (exp_q.size() != 0) check("o_sum", o_sum, exp_q[0]);
    check("o_overflow", o_overflow, m_ovf);
    f = 1'b0;
`ifdef PRODUCT_ACCUMULATOR_FLUSH_EN
    f = flush;
`endif
    pop  = (exp_q.size() != 0) && r;
    push = 1'b0;
    pd   = '0;
    if (f && (m_cnt != 0 || v)) begin
      pd    = m_acc + (v ? 10'(p) : 10'd0);
      push  = 1'b1;
      m_acc = '0;
      m_cnt = 0;
    end else if (v) begin
      if (m_cnt == AccLen - 1) begin
        pd    = m_acc + 10'(p);
        push  = 1'b1;
        m_acc = '0;
        m_cnt = 0;
      end else begin
        m_acc = m_acc + 10'(p);
        m_cnt++;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < 2) exp_q.push_back(pd);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [9:0] val);
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_sum"}, o_sum, val);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    o_ready = 1'b0;
    flush   = 1'b0;
    rst     = 1'b0;
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_sum", o_sum, 0);
    check("rst_overflow", o_overflow, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    i_valid   = 1'b0;
    i_product = '0;
    o_ready   = 1'b0;
    flush     = 1'b0;
    model_clear();
    #2;
    check("init_valid", o_valid, 0);
    check("init_sum", o_sum, 0);
    check("init_overflow", o_overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back maximum products.
    for (int i = 0; i < 4; i++) step(1'b1, 8'd225, 1'b1);
    check_head("t1", 10'd900);
    check("t1_ovf", o_overflow, 0);
    step(1'b0, 8'd0, 1'b1);

    // Gap of three idle cycles inside a group.
    step(1'b1, 8'd1, 1'b1);
    step(1'b1, 8'd2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd3, 1'b1);
    step(1'b1, 8'd4, 1'b1);
    check_head("t2", 10'd10);
    step(1'b0, 8'd0, 1'b1);

    // Three groups into a stalled FIFO: third result dropped.
    for (int i = 0; i < 12; i++) step(1'b1, 8'd1, 1'b0);
    check("t3_ovf", o_overflow, 1);
    check_head("t3_a", 10'd4);
    step(1'b0, 8'd0, 1'b1);
    check_head("t3_b", 10'd4);
    step(1'b0, 8'd0, 1'b1);
    check("t3_empty", o_valid, 0);
    step(1'b0, 8'd0, 1'b1);

    // Reset with a buffered result and a partial group (5,5) pending.
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd5, 1'b0);
    step(1'b1, 8'd5, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b1);
    check_head("t5", 10'd4);
    step(1'b0, 8'd0, 1'b1);

    // Full FIFO with simultaneous pop and push: no overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd4, 1'b0);
    step(1'b1, 8'd4, 1'b1);
    check("t4_ovf", o_overflow, 0);
    check_head("t4_a", 10'd12);
    step(1'b0, 8'd0, 1'b1);
    check_head("t4_b", 10'd16);
    step(1'b0, 8'd0, 1'b1);
    check("t4_empty", o_valid, 0);

`ifdef PRODUCT_ACCUMULATOR_FLUSH_EN
    // Short-group flush, then an idle flush (no-op), then a normal group.
    step(1'b1, 8'd7, 1'b1);
    step(1'b1, 8'd8, 1'b1);
    flush = 1'b1;
    step(1'b0, 8'd0, 1'b1);
    flush = 1'b0;
    check_head("t6_flush", 10'd15);
    step(1'b0, 8'd0, 1'b1);
    flush = 1'b1;
    step(1'b0, 8'd0, 1'b1);
    flush = 1'b0;
    check("t6_noop", o_valid, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b1);
    check_head("t6_group", 10'd4);
    step(1'b0, 8'd0, 1'b1);
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
`ifdef PRODUCT_ACCUMULATOR_FLUSH_EN
      flush = ($urandom_range(0, 9) == 0);
`endif
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 6));
    end
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1);
    check("final_empty", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
